// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared constants and types for the LEGv8 fetch stage
package arm_pkg;

    localparam int N_DEF       = 64;
    localparam int IMEM_AW_DEF = 6;

    localparam logic [31:0] NOP_INSTR  = 32'h8b1f03ff;
    localparam logic [31:0] HALT_INSTR = 32'hb400001f;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with next-PC select (+4, target, hold)
module fetch_pc_reg
    import arm_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         redirect,
    input  logic         hold,
    input  logic [N-1:0] target,
    output logic [N-1:0] pc
);

    // Redirect targets are forced word-aligned; the low bits only feed the misalign flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else if (redirect) begin
            pc <= {target[N-1:2], 2'b00};
        end else if (!hold) begin
            pc <= pc + N'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, IF/ID register, halt FSM and misalign flag
module fetch_stage
    import arm_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int IMEM_AW = IMEM_AW_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [N-1:0]       branch_target_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_q_i,
    output logic [N-1:0]       pc_o,
    output logic [N-1:0]       if_id_pc_o,
    output logic [31:0]        if_id_instr_o,
    output logic               if_id_valid_o,
    output logic               halted_o,
    output logic               misalign_o
);

    fetch_state_t state_q, state_d;
    logic         fetch_en;
    logic         pc_hold;
    logic         bubble;
    logic         halt_word;

    assign halt_word   = (imem_q_i == HALT_INSTR);
    assign imem_addr_o = pc_o[IMEM_AW+1:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (branch_taken_i) begin
            state_d = RUN;
        end else if (!stall_i && state_q == RUN && halt_word) begin
            state_d = HALT;
        end
    end

    // A fetched halt word is still captured, but the PC stops on it.
    always_comb begin
        fetch_en = 1'b0;
        pc_hold  = 1'b1;
        bubble   = 1'b0;
        halted_o = 1'b0;
        if (state_q == HALT) begin
            halted_o = 1'b1;
        end
        if (branch_taken_i) begin
            bubble = 1'b1;
        end else if (!stall_i) begin
            if (state_q == HALT) begin
                bubble = 1'b1;
            end else begin
                fetch_en = 1'b1;
                pc_hold  = halt_word;
            end
        end
    end

    fetch_pc_reg #(
        .N(N)
    ) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .redirect(branch_taken_i),
        .hold    (pc_hold),
        .target  (branch_target_i),
        .pc      (pc_o)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_id_pc_o    <= '0;
            if_id_instr_o <= NOP_INSTR;
            if_id_valid_o <= 1'b0;
        end else if (bubble) begin
            if_id_instr_o <= NOP_INSTR;
            if_id_valid_o <= 1'b0;
        end else if (fetch_en) begin
            if_id_pc_o    <= pc_o;
            if_id_instr_o <= imem_q_i;
            if_id_valid_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_o <= 1'b0;
        end else if (branch_taken_i && (branch_target_i[1:0] != 2'b00)) begin
            misalign_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
    import arm_pkg::*;

    localparam int N  = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          stall_i;
    logic          branch_taken_i;
    logic [N-1:0]  branch_target_i;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_q_i;
    logic [N-1:0]  pc_o;
    logic [N-1:0]  if_id_pc_o;
    logic [31:0]   if_id_instr_o;
    logic          if_id_valid_o;
    logic          halted_o;
    logic          misalign_o;

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [N-1:0] m_pc, m_ipc;
    logic [31:0]  m_instr;
    logic         m_valid, m_halt, m_mis;

    fetch_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .imem_addr_o    (imem_addr_o),
        .imem_q_i       (imem_q_i),
        .pc_o           (pc_o),
        .if_id_pc_o     (if_id_pc_o),
        .if_id_instr_o  (if_id_instr_o),
        .if_id_valid_o  (if_id_valid_o),
        .halted_o       (halted_o),
        .misalign_o     (misalign_o)
    );

    always #5 clk = ~clk;

    assign imem_q_i = mem[imem_addr_o];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the stage must hold after each edge, from the fetch rules.
    always @(posedge clk or negedge reset_n) begin
        logic [31:0] w;
        if (!reset_n) begin
            m_pc = 0; m_ipc = 0; m_instr = NOP_INSTR;
            m_valid = 0; m_halt = 0; m_mis = 0;
        end else if (branch_taken_i) begin
            if (branch_target_i % 4 != 0) m_mis = 1;
            m_pc = branch_target_i - (branch_target_i % 4);
            m_instr = NOP_INSTR; m_valid = 0; m_halt = 0;
        end else if (stall_i) begin
            m_pc = m_pc;
        end else if (m_halt) begin
            m_instr = NOP_INSTR; m_valid = 0;
        end else begin
            w = mem[(m_pc / 4) % 64];
            m_instr = w; m_ipc = m_pc; m_valid = 1;
            if (w == HALT_INSTR) m_halt = 1;
            else m_pc = m_pc + 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc_o, m_pc);
            chk("imem_addr", 64'(imem_addr_o), (m_pc / 4) % 64);
            chk("if_id_pc", if_id_pc_o, m_ipc);
            chk("if_id_instr", 64'(if_id_instr_o), 64'(m_instr));
            chk("if_id_valid", 64'(if_id_valid_o), 64'(m_valid));
            chk("halted", 64'(halted_o), 64'(m_halt));
            chk("misalign", 64'(misalign_o), 64'(m_mis));
        end
    end

    task automatic cyc(input logic s, input logic b, input logic [N-1:0] t);
        stall_i = s; branch_taken_i = b; branch_target_i = t;
        @(posedge clk);
        #2;
        stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h9100_0000 | 32'(i);
        mem[23] = HALT_INSTR;
        reset_n = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("rst_pc", pc_o, 64'h0);
        chk("rst_instr", 64'(if_id_instr_o), 64'h8b1f03ff);
        chk("rst_valid", 64'(if_id_valid_o), 64'h0);
        reset_n = 1'b1;
        #1;
        chk("first_valid", 64'(if_id_valid_o), 64'h0);

        cyc(0, 0, 0);
        chk("f1_pc", pc_o, 64'h4);
        chk("f1_addr", 64'(imem_addr_o), 64'h1);
        chk("f1_ifpc", if_id_pc_o, 64'h0);
        chk("f1_valid", 64'(if_id_valid_o), 64'h1);
        cyc(0, 0, 0);
        chk("f2_pc", pc_o, 64'h8);
        chk("f2_addr", 64'(imem_addr_o), 64'h2);
        cyc(0, 0, 0);
        chk("f3_pc", pc_o, 64'hC);
        chk("f3_addr", 64'(imem_addr_o), 64'h3);
        chk("f3_ifpc", if_id_pc_o, 64'h8);
        cyc(0, 0, 0);
        chk("pre_stall_pc", pc_o, 64'h10);

        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("stall_pc", pc_o, 64'h10);
        chk("stall_ifpc", if_id_pc_o, 64'hC);
        chk("stall_instr", 64'(if_id_instr_o), 64'h9100_0003);
        cyc(0, 0, 0);
        chk("resume_pc", pc_o, 64'h14);
        chk("resume_ifpc", if_id_pc_o, 64'h10);

        cyc(1, 1, 64'h20);
        chk("br_pc", pc_o, 64'h20);
        chk("br_instr", 64'(if_id_instr_o), 64'h8b1f03ff);
        chk("br_valid", 64'(if_id_valid_o), 64'h0);
        cyc(0, 0, 0);
        chk("br_ifpc", if_id_pc_o, 64'h20);
        chk("br_ifinstr", 64'(if_id_instr_o), 64'h9100_0008);

        cyc(0, 1, 64'h15C);
        cyc(0, 0, 0);
        chk("halt_flag", 64'(halted_o), 64'h1);
        chk("halt_pc", pc_o, 64'h15C);
        chk("halt_instr", 64'(if_id_instr_o), 64'hb400001f);
        chk("halt_valid", 64'(if_id_valid_o), 64'h1);
        cyc(0, 0, 0);
        chk("halt_bubble", 64'(if_id_valid_o), 64'h0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("halt_hold_pc", pc_o, 64'h15C);
        cyc(0, 1, 64'h0);
        chk("unhalt", 64'(halted_o), 64'h0);
        chk("unhalt_pc", pc_o, 64'h0);
        cyc(0, 0, 0);

        cyc(0, 1, 64'h22);
        chk("mis_pc", pc_o, 64'h20);
        chk("mis_flag", 64'(misalign_o), 64'h1);
        cyc(0, 0, 0);
        cyc(0, 1, 64'h40);
        chk("mis_sticky", 64'(misalign_o), 64'h1);
        cyc(0, 1, 64'hFC);
        cyc(0, 0, 0);
        chk("alias_pc", pc_o, 64'h100);
        chk("alias_addr", 64'(imem_addr_o), 64'h0);
        cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 0, 0);
        chk("wrap_pc", pc_o, 64'h0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_pc", pc_o, 64'h0);
        chk("arst_valid", 64'(if_id_valid_o), 64'h0);
        chk("arst_mis", 64'(misalign_o), 64'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        cyc(0, 0, 0);
        chk("post_rst_pc", pc_o, 64'h4);
        cyc(0, 0, 0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
